// File: rtl/ecc_scrub_engine.sv
// Background SECDED scrubber: reads each SRAM word, writes back single-error
// corrections and logs double errors. Define ECC_SCRUB_VERIFY_EN to re-read each written word.
module ecc_scrub_engine #(
  parameter int ADDR_W   = 8,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_en,
  input  logic              ded_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [38:0]       mem_rdata,
  output logic [31:0]       dec_din,
  output logic [6:0]        dec_ecc_in,
  input  logic [31:0]       dec_dout,
  input  logic [6:0]        dec_ecc_out,
  input  logic              dec_single,
  input  logic              dec_double,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic [ADDR_W-1:0] last_ded_addr,
  output logic              ded_irq,
  output logic              hard_err
);

  localparam int IW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WB_REQ,
`ifdef ECC_SCRUB_VERIFY_EN
    S_VF_REQ,
    S_VF_WAIT,
    S_VF_CHECK,
`endif
    S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     ivl_q, ivl_d;
  logic [38:0]       rdata_q, rdata_d;
  logic [38:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  sec_q, sec_d;
  logic [CNT_W-1:0]  ded_q, ded_d;
  logic [ADDR_W-1:0] last_ded_q, last_ded_d;
  logic              ded_irq_q, ded_irq_d;
  logic              ded_set;
`ifdef ECC_SCRUB_VERIFY_EN
  logic              hard_err_q, hard_err_d;
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ivl_d      = ivl_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    sec_d      = sec_q;
    ded_d      = ded_q;
    last_ded_d = last_ded_q;
    ded_set    = 1'b0;
`ifdef ECC_SCRUB_VERIFY_EN
    hard_err_d = hard_err_q;
`endif
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pass_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          state_d = S_WAIT;
          ivl_d   = IW'(INTERVAL);
        end
      end
      S_WAIT: begin
        if (ivl_q == '0) state_d = S_RD_REQ;
        else             ivl_d   = ivl_q - IW'(1);
      end
      S_RD_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // A double error outranks a simultaneous single indication.
        if (dec_double) begin
          ded_d      = (&ded_q) ? ded_q : ded_q + CNT_W'(1);
          last_ded_d = addr_q;
          ded_set    = 1'b1;
          state_d    = S_NEXT;
        end else if (dec_single) begin
          sec_d   = (&sec_q) ? sec_q : sec_q + CNT_W'(1);
          wdata_d = {dec_ecc_out, dec_dout};
          state_d = S_WB_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
`ifdef ECC_SCRUB_VERIFY_EN
        if (mem_gnt) state_d = S_VF_REQ;
`else
        if (mem_gnt) state_d = S_NEXT;
`endif
      end
`ifdef ECC_SCRUB_VERIFY_EN
      S_VF_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_VF_WAIT;
      end
      S_VF_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_VF_CHECK;
        end
      end
      S_VF_CHECK: begin
        if (dec_single || dec_double) begin
          hard_err_d = 1'b1;
          last_ded_d = addr_q;
        end
        state_d = S_NEXT;
      end
`endif
      S_NEXT: begin
        addr_d    = addr_q + ADDR_W'(1);
        pass_done = &addr_q;
        if (scrub_en) begin
          state_d = S_WAIT;
          ivl_d   = IW'(INTERVAL);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new double error wins over a coincident clear.
    if (ded_set)      ded_irq_d = 1'b1;
    else if (ded_clr) ded_irq_d = 1'b0;
    else              ded_irq_d = ded_irq_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      ivl_q      <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      sec_q      <= '0;
      ded_q      <= '0;
      last_ded_q <= '0;
      ded_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ivl_q      <= ivl_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      sec_q      <= sec_d;
      ded_q      <= ded_d;
      last_ded_q <= last_ded_d;
      ded_irq_q  <= ded_irq_d;
    end
  end

`ifdef ECC_SCRUB_VERIFY_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) hard_err_q <= 1'b0;
    else        hard_err_q <= hard_err_d;
  end
  assign hard_err = hard_err_q;
`else
  assign hard_err = 1'b0;
`endif

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign dec_din       = rdata_q[31:0];
  assign dec_ecc_in    = rdata_q[38:32];
  assign busy          = (state_q != S_IDLE);
  assign sec_count     = sec_q;
  assign ded_count     = ded_q;
  assign last_ded_addr = last_ded_q;
  assign ded_irq       = ded_irq_q;

endmodule
